// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers, with a per-owner burst limit.
// Optional statistics counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic                            fifo_full,
`ifdef FIFO_WR_ARB_STATS_EN
   input  logic                            stats_clr,
   output logic [NUM_REQ*16-1:0]           grant_cnt,
   output logic [15:0]                     stall_cnt,
`endif
   output logic [NUM_REQ-1:0]              gnt,
   output logic                            fifo_w_en,
   output logic [DATA_WIDTH-1:0]           fifo_data_in,
   output logic [$clog2(NUM_REQ)-1:0]      owner,
   output logic                            busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int BW    = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, OWN} state_t;

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;
   logic [BW-1:0]    burst_cnt;

   logic             keep;
   logic             rot_found;
   logic [PTR_W-1:0] rot_idx;
   logic             grant_any;
   logic [PTR_W-1:0] grant_idx;
   int               idx;

   // Search downward so the last hit is the closest requester at or after rr_ptr.
   always_comb begin
      rot_found = 1'b0;
      rot_idx   = '0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx]) begin
            rot_found = 1'b1;
            rot_idx   = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      keep      = (state == OWN) && req[owner] && (burst_cnt < BW'(MAX_BURST));
      grant_any = 1'b0;
      grant_idx = owner;
      if (rst_n && !fifo_full) begin
         if (keep) begin
            grant_any = 1'b1;
            grant_idx = owner;
         end else if (rot_found) begin
            grant_any = 1'b1;
            grant_idx = rot_idx;
         end
      end
   end

   always_comb begin
      gnt          = '0;
      fifo_data_in = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_any && grant_idx == PTR_W'(i)) begin
            gnt[i]       = 1'b1;
            fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      fifo_w_en = grant_any;
   end

   // A full FIFO freezes every piece of arbitration state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         busy      <= 1'b0;
      end else if (!fifo_full) begin
         if (keep) begin
            burst_cnt <= burst_cnt + BW'(1);
         end else if (rot_found) begin
            state     <= OWN;
            owner     <= rot_idx;
            burst_cnt <= BW'(1);
            rr_ptr    <= (rot_idx == PTR_W'(NUM_REQ - 1)) ? '0 : rot_idx + PTR_W'(1);
            busy      <= 1'b1;
         end else begin
            state     <= IDLE;
            burst_cnt <= '0;
            busy      <= 1'b0;
         end
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   // Saturating counters; a clear in the same cycle as an increment wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else if (stats_clr) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
               grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
         end
         if (|req && fifo_full && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one synchronous_fifo write port between NUM_REQ producers.
- Selects at most one producer per cycle.
- Drives the FIFO w_en/data_in combinationally from the selected producer.
- Never writes while the FIFO reports full.
- A burst limit keeps one producer from monopolising the FIFO.

Parameters:
NUM_REQ, 4, number of producers (2..16)
DATA_WIDTH, 8, FIFO data width in bits
MAX_BURST, 4, max consecutive grants to one producer while others request (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-producer write request, held until granted
req_data  input  NUM_REQ*DATA_WIDTH  producer data, slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
gnt  output  NUM_REQ  one-hot grant; producer i's word is written this cycle when gnt[i]=1
fifo_full  input  1  FIFO full flag
fifo_w_en  output  1  FIFO write enable, equals |gnt
fifo_data_in  output  DATA_WIDTH  req_data slice of the granted producer, 0 when no grant
owner  output  $clog2(NUM_REQ)  index of last granted producer (registered)
busy  output  1  registered; 1 while the arbiter is in OWN

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, owner=0, rr_ptr=0, burst_cnt=0, busy=0. While rst_n=0, gnt=0, fifo_w_en=0 and fifo_data_in=0, forced combinationally.
- Handshake:
  - Transfer occurs in any cycle with req[i]=1 and gnt[i]=1. Zero-cycle grant latency.
  - gnt is combinational from req, fifo_full and registered state. It is never asserted when fifo_full=1 or when req[i]=0.
  - A producer must hold req and data stable until granted. Dropping req before grant is legal (request withdrawn).
- FSM states: IDLE (no owner) and OWN (owner valid, burst_cnt in 1..MAX_BURST).
- Selection each cycle, when fifo_full=0:
  - Keep: in OWN with req[owner]=1 and burst_cnt<MAX_BURST -> grant owner; burst_cnt++.
  - Otherwise rotate: pick the first i with req[i]=1, searching from rr_ptr upward with wrap at NUM_REQ-1 -> 0. Grant i, owner<=i, burst_cnt<=1, rr_ptr<=(i+1) mod NUM_REQ, state<=OWN.
  - Burst exhausted, owner the only requester: owner is re-granted through the rotate path, burst_cnt<=1, no bubble cycle.
  - No request: state<=IDLE, burst_cnt<=0, busy<=0. owner and rr_ptr are held.
- fifo_full=1: no grant; state, owner, burst_cnt and rr_ptr are all held. Selection resumes in the first cycle fifo_full=0.
- Simultaneous req and full: full wins; no write, no pointer update.
- MAX_BURST=1: pure per-word round-robin.
- Reset mid-burst: all state clears immediately. The word presented in the cycle rst_n falls is not written, and the producer must re-request.

Optional Feature:
Macro FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16 bits): per-producer 16-bit saturating counters, incremented on each gnt[i].
  - Adds output stall_cnt (16 bits): saturating counter incremented each cycle with |req=1 and fifo_full=1.
  - Adds input stats_clr (1 bit): synchronous clear of all counters. When clear and increment coincide, clear wins.
  - All counters reset to 0 on rst_n.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 and fifo_full=0 -> gnt=0, fifo_w_en=0, busy=0, owner=0. Release -> first grant gnt=4'b0001 on the next cycle.
- Burst limit: req=4'b0011 held, MAX_BURST=4, fifo_full=0 -> gnt sequence 0001 x4, 0010 x4, 0001 x4. fifo_data_in matches the granted slice each cycle.
- Sole requester: req=4'b0100 only for 10 cycles -> gnt=4'b0100 every cycle with no gap. owner=2, busy=1.
- Full stall: grant producer 1 twice (burst_cnt=2), then fifo_full=1 for 3 cycles -> gnt=0 and fifo_w_en=0. On full deassert, producer 1 gets 2 more grants (burst_cnt resumes at 2), then rotation.
- Wrap-around and withdrawal: owner=3, req=4'b1001, producer 3 drops req -> next grant is producer 0 (rr_ptr wrapped to 0). Then req=4'b0110 -> producer 1.
- Stats build (FIFO_WR_ARB_STATS_EN): 5 grants to producer 2 plus 3 full-stall cycles -> grant_cnt[2]=5, stall_cnt=3. Pulse stats_clr -> all counters 0 on the next cycle.
